// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush scheduler
//
// Purpose : memory-op and FSM-state enumerations used by pipe_ctrl and its
//           hazard sub-module, plus the architectural zero-register index.
// Contents: mem_op_t, pipe_state_t, REG_ZERO.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'd0,
        MEM_OP_LOAD  = 2'd1,
        MEM_OP_STORE = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } pipe_state_t;

    // Wide enough for any register-address width; users slice the low bits.
    localparam logic [31:0] REG_ZERO = '0;

endpackage

// File: rtl/pipe_ctrl_hazard_unit.sv
// rtl/pipe_ctrl_hazard_unit.sv - combinational load-use hazard detector
//
// Purpose : flags an ID-stage instruction that reads the destination of a
//           load currently in EX. Shared with the forwarding logic.
// Ports   : id_rs1_addr/id_rs2_addr, id_rs1_used/id_rs2_used - ID sources
//           ex_rd_addr, ex_mem_op                           - EX producer
//           load_use                                        - hazard flag
module pipe_ctrl_hazard_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  mem_op_t               ex_mem_op,
    output logic                  load_use
);

    logic rs1_hit;
    logic rs2_hit;
    logic ex_is_load;

    always_comb begin
        ex_is_load = (ex_mem_op == MEM_OP_LOAD) &&
                     (ex_rd_addr != REG_ZERO[REG_ADDR_W-1:0]);
        rs1_hit    = id_rs1_used && (id_rs1_addr == ex_rd_addr);
        rs2_hit    = id_rs2_used && (id_rs2_addr == ex_rd_addr);
        load_use   = ex_is_load && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage pipeline stall/flush scheduler
//
// Purpose : drives per-register enables and flush/bubble controls for the
//           PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, resolving memory
//           waits (with timeout), EX redirects and load-use hazards.
// Ports   : clk, rst_n (async, active-low)
//           id_rs1_addr/id_rs2_addr/id_rs1_used/id_rs2_used - ID sources
//           ex_rd_addr, ex_mem_op, ex_redirect              - EX stage
//           mem_req, dmem_ack                               - MEM stage
//           pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
//           ex_mem_en, mem_wb_en, mem_wb_bubble             - controls
//           bus_err (sticky timeout), stall_cycles (saturating)
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 255,
    parameter int TMO_W       = 8,
    parameter int STAT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  mem_op_t               ex_mem_op,
    input  logic                  ex_redirect,
    input  logic                  mem_req,
    input  logic                  dmem_ack,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_en,
    output logic                  id_ex_flush,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  mem_wb_bubble,
    output logic                  bus_err,
    output logic [STAT_W-1:0]     stall_cycles
);

    pipe_state_t      state;
    pipe_state_t      state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_nxt;
    logic [TMO_W-1:0] tmo_inc;
    logic             tmo_hit;
    logic             bus_err_nxt;
    logic             load_use;
    logic             mem_stall;

    pipe_ctrl_hazard_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_unit (
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_rd_addr  (ex_rd_addr),
        .ex_mem_op   (ex_mem_op),
        .load_use    (load_use)
    );

    // The first wait cycle happens in RUN, so the count there starts at 1;
    // tmo_inc is the number of wait cycles including the current one.
    always_comb begin
        mem_stall = ((state == RUN) && mem_req && !dmem_ack) ||
                    ((state == MEM_WAIT) && !dmem_ack);
        tmo_inc   = (state == RUN) ? TMO_W'(1) : tmo_cnt + TMO_W'(1);
        tmo_hit   = (tmo_inc == TMO_W'(MEM_TIMEOUT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            tmo_cnt <= '0;
            bus_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_nxt;
            bus_err <= bus_err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tmo_nxt     = tmo_cnt;
        bus_err_nxt = bus_err;
        case (state)
            RUN, MEM_WAIT: begin
                if (mem_stall) begin
                    if (tmo_hit) begin
                        state_nxt   = ERROR;
                        tmo_nxt     = '0;
                        bus_err_nxt = 1'b1;
                    end else begin
                        state_nxt   = MEM_WAIT;
                        tmo_nxt     = tmo_inc;
                    end
                end else begin
                    // Ack (or no request) releases the wait, even on the
                    // cycle the count would have reached the limit.
                    state_nxt = RUN;
                    tmo_nxt   = '0;
                end
            end
            ERROR:   state_nxt = ERROR;
            default: begin
                state_nxt = RUN;
                tmo_nxt   = '0;
            end
        endcase
    end

    // Priority: ERROR > mem_stall > redirect > load_use > normal.
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        mem_wb_bubble = 1'b0;
        if (!rst_n) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_en      = 1'b0;
            id_ex_flush   = 1'b1;
            ex_mem_en     = 1'b0;
            mem_wb_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (state == ERROR) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (mem_stall) begin
            // EX contents are frozen, so redirect/load-use wait for release.
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (ex_redirect) begin
            // ID holds a wrong-path instruction, so its load-use is moot.
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
        end else if (load_use) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_flush   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (!pc_en && (stall_cycles != {STAT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int STAT_W = 2;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en, mem_wb_bubble}
    localparam logic [7:0] C_RST   = 8'b0010_1001;
    localparam logic [7:0] C_NORM  = 8'b1101_0110;
    localparam logic [7:0] C_STALL = 8'b0000_0011;
    localparam logic [7:0] C_REDIR = 8'b1111_1110;
    localparam logic [7:0] C_LU    = 8'b0001_1110;
    localparam logic [7:0] C_ERR   = 8'b0000_0001;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [4:0]        id_rs1_addr;
    logic [4:0]        id_rs2_addr;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [4:0]        ex_rd_addr;
    mem_op_t           ex_mem_op;
    logic              ex_redirect;
    logic              mem_req;
    logic              dmem_ack;
    logic              pc_en;
    logic              if_id_en;
    logic              if_id_flush;
    logic              id_ex_en;
    logic              id_ex_flush;
    logic              ex_mem_en;
    logic              mem_wb_en;
    logic              mem_wb_bubble;
    logic              bus_err;
    logic [STAT_W-1:0] stall_cycles;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .REG_ADDR_W  (5),
        .MEM_TIMEOUT (4),
        .TMO_W       (8),
        .STAT_W      (STAT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs2_addr   (id_rs2_addr),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_used   (id_rs2_used),
        .ex_rd_addr    (ex_rd_addr),
        .ex_mem_op     (ex_mem_op),
        .ex_redirect   (ex_redirect),
        .mem_req       (mem_req),
        .dmem_ack      (dmem_ack),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .if_id_flush   (if_id_flush),
        .id_ex_en      (id_ex_en),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_en     (ex_mem_en),
        .mem_wb_en     (mem_wb_en),
        .mem_wb_bubble (mem_wb_bubble),
        .bus_err       (bus_err),
        .stall_cycles  (stall_cycles)
    );

    task automatic check(input string tag, input logic [7:0] exp_ctrl,
                         input logic exp_berr, input logic [STAT_W-1:0] exp_stall);
        logic [STAT_W+8:0] obs;
        logic [STAT_W+8:0] exp;
        obs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wb_en, mem_wb_bubble, bus_err, stall_cycles};
        exp = {exp_ctrl, exp_berr, exp_stall};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed ctrl/berr/stall=%b expected %b", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled 3 later.
    task automatic drive(input mem_op_t op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic red,
                         input logic req, input logic ack);
        ex_mem_op   = op;
        ex_rd_addr  = rd;
        id_rs1_addr = rs1;
        id_rs2_addr = rs2;
        id_rs1_used = u1;
        id_rs2_used = u2;
        ex_redirect = red;
        mem_req     = req;
        dmem_ack    = ack;
        #3;
    endtask

    task automatic idle();
        drive(MEM_OP_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        next_cycle();
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        check("reset", C_RST, 1'b0, 2'd0);
        next_cycle();
        rst_n = 1'b1;
        idle();
        check("post_reset", C_NORM, 1'b0, 2'd0);

        // load-use hazards
        next_cycle(); drive(MEM_OP_LOAD, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lu_rs1", C_LU, 1'b0, 2'd0);
        next_cycle(); idle();
        check("lu_release", C_NORM, 1'b0, 2'd1);
        next_cycle(); drive(MEM_OP_LOAD, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lu_rs2", C_LU, 1'b0, 2'd1);
        next_cycle(); drive(MEM_OP_LOAD, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lu_rd_zero", C_NORM, 1'b0, 2'd2);
        next_cycle(); drive(MEM_OP_LOAD, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lu_src_unused", C_NORM, 1'b0, 2'd2);
        next_cycle(); drive(MEM_OP_STORE, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("store_no_lu", C_NORM, 1'b0, 2'd2);

        // zero-wait and three-cycle wait accesses
        reset_pulse();
        next_cycle(); drive(MEM_OP_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("zero_wait", C_NORM, 1'b0, 2'd0);
        next_cycle(); idle();
        check("zero_wait_after", C_NORM, 1'b0, 2'd0);
        next_cycle(); drive(MEM_OP_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("wait_c1", C_STALL, 1'b0, 2'd0);
        next_cycle(); check("wait_c2", C_STALL, 1'b0, 2'd1);
        next_cycle(); check("wait_c3", C_STALL, 1'b0, 2'd2);
        next_cycle(); drive(MEM_OP_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("wait_ack", C_NORM, 1'b0, 2'd3);
        next_cycle(); idle();
        check("wait_done", C_NORM, 1'b0, 2'd3);

        // redirect priority and deferral
        reset_pulse();
        next_cycle(); drive(MEM_OP_LOAD, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("redir_over_lu", C_REDIR, 1'b0, 2'd0);
        next_cycle(); drive(MEM_OP_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("redir_in_stall1", C_STALL, 1'b0, 2'd0);
        next_cycle(); check("redir_in_stall2", C_STALL, 1'b0, 2'd1);
        next_cycle(); drive(MEM_OP_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        check("redir_on_ack", C_REDIR, 1'b0, 2'd2);
        next_cycle(); idle();
        check("redir_done", C_NORM, 1'b0, 2'd2);
        next_cycle(); drive(MEM_OP_LOAD, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("lu_in_stall", C_STALL, 1'b0, 2'd2);
        next_cycle(); drive(MEM_OP_LOAD, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("lu_on_ack", C_LU, 1'b0, 2'd3);
        next_cycle(); idle();
        check("lu_ack_done", C_NORM, 1'b0, 2'd3);

        // timeout into ERROR, stall counter saturation
        reset_pulse();
        next_cycle(); drive(MEM_OP_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("tmo_c1", C_STALL, 1'b0, 2'd0);
        next_cycle(); check("tmo_c2", C_STALL, 1'b0, 2'd1);
        next_cycle(); check("tmo_c3", C_STALL, 1'b0, 2'd2);
        next_cycle(); check("tmo_c4", C_STALL, 1'b0, 2'd3);
        next_cycle(); check("tmo_error", C_ERR, 1'b1, 2'd3);
        next_cycle(); drive(MEM_OP_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("error_held_sat", C_ERR, 1'b1, 2'd3);
        rst_n = 1'b0;
        #1;
        check("reset_in_error", C_RST, 1'b0, 2'd0);
        next_cycle();
        rst_n = 1'b1;
        idle();
        check("error_cleared", C_NORM, 1'b0, 2'd0);

        // ack on the limit cycle wins
        next_cycle(); drive(MEM_OP_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("lim_c1", C_STALL, 1'b0, 2'd0);
        next_cycle(); check("lim_c2", C_STALL, 1'b0, 2'd1);
        next_cycle(); check("lim_c3", C_STALL, 1'b0, 2'd2);
        next_cycle(); drive(MEM_OP_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("lim_ack_c4", C_NORM, 1'b0, 2'd3);
        next_cycle(); idle();
        check("lim_after", C_NORM, 1'b0, 2'd3);

        // asynchronous reset in the middle of MEM_WAIT
        reset_pulse();
        next_cycle(); drive(MEM_OP_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("mw_c1", C_STALL, 1'b0, 2'd0);
        next_cycle(); check("mw_c2", C_STALL, 1'b0, 2'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_in_wait", C_RST, 1'b0, 2'd0);
        next_cycle();
        rst_n = 1'b1;
        idle();
        check("run_after_reset", C_NORM, 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
